// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM states, datapath mux selects and the one-hot instruction class.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_GPR    = 2'd3;

  localparam logic [1:0] A3_RT     = 2'd0;
  localparam logic [1:0] A3_RD     = 2'd1;
  localparam logic [1:0] A3_RA     = 2'd2;

  localparam logic [1:0] WD_ALU    = 2'd0;
  localparam logic [1:0] WD_DMR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;
  localparam logic [1:0] WD_LUI    = 2'd3;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;

  typedef struct packed {
    logic rcal;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } ins_class_t;

endpackage

// File: rtl/mc_ctrl_ins_decode.sv
// Combinational opcode/funct classifier; exactly one class bit is set.
module mc_ctrl_ins_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ins_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls.rcal    = 1'b1;
          FN_JR:            cls.jr      = 1'b1;
          default:          cls.illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS subset datapath.
// state | meaning: FETCH load IR, PC+=4 | DECODE jumps/lui retire | EXEC ALU op, beq resolves | MEM DM access | WB RF write | HALT trapped
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] pc_sel,
  output logic [1:0] a3_sel,
  output logic [1:0] wd_sel,
  output logic       alu_b_sel,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic [2:0] state,
  output logic       retire,
  output logic       halted
);

  state_e     state_q, state_d;
  ins_class_t cls;

  mc_ctrl_ins_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    pc_sel    = PC_PLUS4;
    a3_sel    = A3_RT;
    wd_sel    = WD_ALU;
    alu_b_sel = 1'b0;
    ext_op    = 1'b0;
    alu_op    = ALU_ADD;
    retire    = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = PC_PLUS4;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
        if (cls.j || cls.jal) begin
          pc_we   = 1'b1;
          pc_sel  = PC_JUMP;
          retire  = 1'b1;
          state_d = ST_FETCH;
          if (cls.jal) begin
            // PC already holds PC+4 of this instruction; RF captures it on this edge
            reg_we = 1'b1;
            a3_sel = A3_RA;
            wd_sel = WD_PC;
          end
        end else if (cls.jr) begin
          pc_we   = 1'b1;
          pc_sel  = PC_GPR;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.lui) begin
          reg_we  = 1'b1;
          a3_sel  = A3_RT;
          wd_sel  = WD_LUI;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (cls.illegal) begin
          if (ILLEGAL_TRAP) begin
            state_d = ST_HALT;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        if (cls.rcal) begin
          alu_op  = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
          state_d = ST_WB;
        end else if (cls.ori) begin
          ext_op    = 1'b0;
          alu_b_sel = 1'b1;
          alu_op    = ALU_OR;
          state_d   = ST_WB;
        end else if (cls.lw || cls.sw) begin
          ext_op    = 1'b1;
          alu_b_sel = 1'b1;
          alu_op    = ALU_ADD;
          state_d   = ST_MEM;
        end else if (cls.beq) begin
          alu_op = ALU_SUB;
          retire = 1'b1;
          if (zero) begin
            pc_we  = 1'b1;
            pc_sel = PC_BRANCH;
          end
        end
      end

      ST_MEM: begin
        state_d = ST_FETCH;
        if (cls.sw) begin
          mem_we = 1'b1;
          retire = 1'b1;
        end else if (cls.lw) begin
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        if (cls.rcal) begin
          a3_sel = A3_RD;
          wd_sel = WD_ALU;
        end else if (cls.lw) begin
          a3_sel = A3_RT;
          wd_sel = WD_DMR;
        end else begin
          a3_sel = A3_RT;
          wd_sel = WD_ALU;
        end
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: state_d = ST_FETCH;
    endcase

    // The FETCH decode above would otherwise leak enables while reset is held
    if (reset) begin
      state_d   = ST_FETCH;
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      mem_we    = 1'b0;
      pc_sel    = PC_PLUS4;
      a3_sel    = A3_RT;
      wd_sel    = WD_ALU;
      alu_b_sel = 1'b0;
      ext_op    = 1'b0;
      alu_op    = ALU_ADD;
      retire    = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected output vectors are queued
// per instruction and popped/compared one per clock.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we, ir_we, reg_we, mem_we;
  logic [1:0] pc_sel, a3_sel, wd_sel;
  logic       alu_b_sel, ext_op;
  logic [2:0] alu_op;
  logic [2:0] state;
  logic       retire, halted;

  int errors = 0;
  int checks = 0;

  logic [19:0] exp_q[$];
  string       tag_q[$];

  mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .mem_we    (mem_we),
    .pc_sel    (pc_sel),
    .a3_sel    (a3_sel),
    .wd_sel    (wd_sel),
    .alu_b_sel (alu_b_sel),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .state     (state),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // {state, pc_we, ir_we, reg_we, mem_we, pc_sel, a3_sel, wd_sel, alu_b_sel, ext_op, alu_op, retire, halted}
  function automatic logic [19:0] vec(input logic [2:0] st, input logic pcw, input logic irw,
                                      input logic rw, input logic mw, input logic [1:0] ps,
                                      input logic [1:0] a3, input logic [1:0] wd, input logic bs,
                                      input logic ex, input logic [2:0] ao, input logic ret,
                                      input logic hlt);
    return {st, pcw, irw, rw, mw, ps, a3, wd, bs, ex, ao, ret, hlt};
  endfunction

  task automatic push(input string tag, input logic [19:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input string tag, input logic [19:0] exp_v);
    logic [19:0] obs;
    obs = {state, pc_we, ir_we, reg_we, mem_we, pc_sel, a3_sel, wd_sel,
           alu_b_sel, ext_op, alu_op, retire, halted};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drains the scoreboard, one cycle per entry, starting in the current cycle
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
    while (exp_q.size() > 0) begin
      opcode = op;
      funct  = fn;
      zero   = z;
      #1;
      chk(tag_q.pop_front(), exp_q.pop_front());
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic go(input logic [5:0] op, input logic [5:0] fn, input logic z);
    @(negedge clk);
    run(op, fn, z);
  endtask

  logic [19:0] V_RST, V_F, V_D;

  initial begin
    V_RST = '0;
    V_F   = vec(ST_FETCH, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_D   = vec(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    @(negedge clk); #1; chk("rst_hold0", V_RST);
    @(negedge clk); #1; chk("rst_hold1", V_RST);
    reset = 1'b0;

    // addu
    push("addu_f", V_F); push("addu_d", V_D);
    push("addu_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
    push("addu_wb", vec(ST_WB, 0, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 1, 0));
    run(6'h00, 6'h21, 1'b0);

    // subu
    push("subu_f", V_F); push("subu_d", V_D);
    push("subu_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0));
    push("subu_wb", vec(ST_WB, 0, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 1, 0));
    go(6'h00, 6'h23, 1'b1);

    // ori
    push("ori_f", V_F); push("ori_d", V_D);
    push("ori_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd2, 0, 0));
    push("ori_wb", vec(ST_WB, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0));
    go(6'h0D, 6'h21, 1'b0);

    // lw: 5 cycles, mem_we never high
    push("lw_f", V_F); push("lw_d", V_D);
    push("lw_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'd0, 0, 0));
    push("lw_mem", vec(ST_MEM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("lw_wb", vec(ST_WB, 0, 0, 1, 0, 0, 2'd0, 2'd1, 0, 0, 0, 1, 0));
    go(6'h23, 6'h00, 1'b0);

    // sw
    push("sw_f", V_F); push("sw_d", V_D);
    push("sw_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'd0, 0, 0));
    push("sw_mem", vec(ST_MEM, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    go(6'h2B, 6'h00, 1'b0);

    // beq taken then not taken
    push("beqt_f", V_F); push("beqt_d", V_D);
    push("beqt_ex", vec(ST_EXEC, 1, 0, 0, 0, 2'd1, 0, 0, 0, 0, 3'd1, 1, 0));
    go(6'h04, 6'h00, 1'b1);
    push("beqn_f", V_F); push("beqn_d", V_D);
    push("beqn_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 1, 0));
    go(6'h04, 6'h00, 1'b0);

    // jumps and lui retire in DECODE
    push("j_f", V_F);
    push("j_d", vec(ST_DECODE, 1, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 1, 0));
    go(6'h02, 6'h00, 1'b0);
    push("jal_f", V_F);
    push("jal_d", vec(ST_DECODE, 1, 0, 1, 0, 2'd2, 2'd2, 2'd2, 0, 0, 0, 1, 0));
    go(6'h03, 6'h00, 1'b0);
    push("jr_f", V_F);
    push("jr_d", vec(ST_DECODE, 1, 0, 0, 0, 2'd3, 0, 0, 0, 0, 0, 1, 0));
    go(6'h00, 6'h08, 1'b0);
    push("lui_f", V_F);
    push("lui_d", vec(ST_DECODE, 0, 0, 1, 0, 0, 2'd0, 2'd3, 0, 0, 0, 1, 0));
    go(6'h0F, 6'h00, 1'b0);
    push("post_lui_f", V_F);
    go(6'h23, 6'h00, 1'b0);

    // reset asserted mid-EXEC of addu
    @(negedge clk);
    push("mid_d", V_D);
    push("mid_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
    run(6'h00, 6'h21, 1'b0);
    #1 reset = 1'b1;
    #1 chk("mid_rst_async", V_RST);
    @(negedge clk); #1 chk("mid_rst_hold", V_RST);
    reset = 1'b0;
    push("rel_f", V_F); push("rel_d", V_D);
    push("rel_ex", vec(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
    push("rel_wb", vec(ST_WB, 0, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 1, 0));
    run(6'h00, 6'h21, 1'b0);

    // illegal opcode traps
    push("ill_f", V_F); push("ill_d", V_D);
    for (int i = 0; i < 12; i++)
      push($sformatf("halt%0d", i), vec(ST_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(6'h3F, 6'h00, 1'b0);
    #1 reset = 1'b1;
    #1 chk("halt_rst", V_RST);
    reset = 1'b0;
    push("rec_f", V_F);
    push("rec_j", vec(ST_DECODE, 1, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 1, 0));
    run(6'h02, 6'h00, 1'b0);

    // R-type with unknown funct also traps
    push("illfn_f", V_F); push("illfn_d", V_D);
    push("illfn_h", vec(ST_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    go(6'h00, 6'h3F, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
